// File: rtl/vending_machine_change.sv
// Coin-accepting vending FSM: vends at PRICE, then refunds the remainder as a train of 5-unit change pulses.
// All outputs are registered and settle one edge after the coin is sampled; there is no backpressure, and any coin the FSM cannot use is bounced through coin_reject.
module vending_machine_change #(
    parameter int PRICE      = 15,
    parameter int STOCK_INIT = 8,
    parameter int CREDIT_W   = 6,
    parameter int STOCK_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                restock,
    output logic                dispense,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                sold_out,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CREDIT = 2'b01,
        VEND   = 2'b10,
        CHANGE = 2'b11
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] FIVE_C  = CREDIT_W'(5);
    localparam logic [STOCK_W-1:0]  STOCK_C = STOCK_W'(STOCK_INIT);

    state_t              state;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] sum;
    logic                coin_nz;

    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = CREDIT_W'(5);
            2'b10:   coin_val = CREDIT_W'(10);
            2'b11:   coin_val = CREDIT_W'(25);
            default: coin_val = '0;
        endcase
    end

    // Credit below PRICE plus the largest coin stays within PRICE+20, so the sum never wraps.
    assign sum       = credit + coin_val;
    assign coin_nz   = (coin != 2'b00);
    assign sold_out  = (stock == '0);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            credit       <= '0;
            stock        <= STOCK_C;
            dispense     <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
        end else begin
            dispense     <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            case (state)
                IDLE, CREDIT: begin
                    // The coin check below still sees the pre-restock stock value.
                    if (state == IDLE && restock) begin
                        stock <= STOCK_C;
                    end
                    if (state == CREDIT && cancel) begin
                        state        <= CHANGE;
                        change_pulse <= 1'b1;
                        coin_reject  <= coin_nz;
                    end else if (coin_nz) begin
                        if (stock == '0) begin
                            coin_reject <= 1'b1;
                        end else if (sum >= PRICE_C) begin
                            state    <= VEND;
                            credit   <= sum - PRICE_C;
                            dispense <= 1'b1;
                        end else begin
                            state  <= CREDIT;
                            credit <= sum;
                        end
                    end
                end
                VEND: begin
                    stock       <= stock - STOCK_W'(1);
                    coin_reject <= coin_nz;
                    if (credit != '0) begin
                        state        <= CHANGE;
                        change_pulse <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                CHANGE: begin
                    coin_reject <= coin_nz;
                    // Each CHANGE cycle pays out one 5-unit coin; leave once the last one is out.
                    if (credit > FIVE_C) begin
                        credit       <= credit - FIVE_C;
                        change_pulse <= 1'b1;
                    end else begin
                        credit <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_machine_change.sv
// Bench for vending_machine_change: directed vector table, hand sequences, then random traffic against a refund-schedule model.
module tb_vending_machine_change;

    localparam int PRICE      = 15;
    localparam int STOCK_INIT = 8;
    localparam int CW         = 6;
    localparam int SW         = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    coin = 2'b00;
    logic          cancel = 1'b0;
    logic          restock = 1'b0;
    logic          dispense, change_pulse, coin_reject, sold_out;
    logic [CW-1:0] credit;
    logic [SW-1:0] stock;
    logic [1:0]    state_dbg;

    vending_machine_change #(
        .PRICE(PRICE), .STOCK_INIT(STOCK_INIT), .CREDIT_W(CW), .STOCK_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .coin(coin), .cancel(cancel), .restock(restock),
        .dispense(dispense), .change_pulse(change_pulse), .coin_reject(coin_reject),
        .sold_out(sold_out), .credit(credit), .stock(stock), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef logic [2+CW+SW+3:0] obs_t;

    function automatic obs_t pack(input logic [1:0] st, input int cr, input int sk,
                                  input logic d, input logic c, input logic r);
        return {st, CW'(cr), SW'(sk), d, c, r, (sk == 0)};
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = {state_dbg, credit, stock, dispense, change_pulse, coin_reject, sold_out};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got st=%0d cr=%0d stk=%0d d=%0b chg=%0b rej=%0b so=%0b, expected st=%0d cr=%0d stk=%0d d=%0b chg=%0b rej=%0b so=%0b",
                     name, act[15:14], act[13:8], act[7:4], act[3], act[2], act[1], act[0],
                     exp[15:14], exp[13:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Apply inputs across one rising edge and leave the bench 2 time units past it.
    task automatic tick(input logic [1:0] c, input logic cn, input logic r);
        coin = c; cancel = cn; restock = r;
        @(posedge clk);
        #2;
        coin = 2'b00; cancel = 1'b0; restock = 1'b0;
    endtask

    task automatic pulse_reset(input string name);
        reset = 1'b1;
        #1;
        check(name, pack(2'd0, 0, STOCK_INIT, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Model: while a sale or refund is in progress, the upcoming cycles are a queue of scheduled slots.
    typedef struct {
        bit vend;
        int cr;
    } slot_t;

    slot_t q[$];
    int    m_credit;
    int    m_stock;
    bit    m_rej;

    function automatic void model_reset();
        q.delete();
        m_credit = 0;
        m_stock  = STOCK_INIT;
        m_rej    = 1'b0;
    endfunction

    function automatic void schedule(input bit vend, input int amt);
        if (vend) q.push_back('{vend: 1'b1, cr: amt});
        for (int k = amt; k > 0; k -= 5) q.push_back('{vend: 1'b0, cr: k});
    endfunction

    function automatic void model_step(input logic [1:0] c, input logic cn, input logic r);
        int v;
        bit idle;
        v = (c == 2'd1) ? 5 : (c == 2'd2) ? 10 : (c == 2'd3) ? 25 : 0;
        m_rej = 1'b0;
        if (q.size() > 0) begin
            m_rej = (v != 0);
            if (q[0].vend) m_stock--;
            void'(q.pop_front());
        end else begin
            idle = (m_credit == 0);
            if (!idle && cn) begin
                m_rej = (v != 0);
                schedule(1'b0, m_credit);
                m_credit = 0;
            end else if (v != 0) begin
                if (m_stock == 0) m_rej = 1'b1;
                else if (m_credit + v >= PRICE) begin
                    schedule(1'b1, m_credit + v - PRICE);
                    m_credit = 0;
                end else m_credit += v;
            end
            if (idle && r) m_stock = STOCK_INIT;
        end
    endfunction

    function automatic obs_t model_obs();
        if (q.size() > 0)
            return pack(q[0].vend ? 2'd2 : 2'd3, q[0].cr, m_stock, q[0].vend, !q[0].vend, m_rej);
        return pack((m_credit != 0) ? 2'd1 : 2'd0, m_credit, m_stock, 1'b0, 1'b0, m_rej);
    endfunction

    typedef struct {
        logic [1:0] coin;
        logic       cancel;
        logic       restock;
        logic [1:0] st;
        int         cr;
        int         sk;
        logic       d;
        logic       c;
        logic       r;
    } vec_t;

    vec_t vt[24];

    initial begin
        // coin, cancel, restock -> state, credit, stock, dispense, change, reject
        vt[0]  = '{2'd1, 1'b0, 1'b0, 2'd1,  5, 8, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{2'd2, 1'b0, 1'b0, 2'd2,  0, 8, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{2'd0, 1'b0, 1'b0, 2'd0,  0, 7, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{2'd3, 1'b0, 1'b0, 2'd2, 10, 7, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{2'd0, 1'b0, 1'b0, 2'd3, 10, 6, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{2'd0, 1'b0, 1'b0, 2'd3,  5, 6, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{2'd0, 1'b0, 1'b0, 2'd0,  0, 6, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{2'd2, 1'b0, 1'b0, 2'd1, 10, 6, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{2'd0, 1'b1, 1'b0, 2'd3, 10, 6, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{2'd0, 1'b0, 1'b0, 2'd3,  5, 6, 1'b0, 1'b1, 1'b0};
        vt[10] = '{2'd0, 1'b0, 1'b0, 2'd0,  0, 6, 1'b0, 1'b0, 1'b0};
        vt[11] = '{2'd3, 1'b0, 1'b0, 2'd2, 10, 6, 1'b1, 1'b0, 1'b0};
        vt[12] = '{2'd0, 1'b0, 1'b0, 2'd3, 10, 5, 1'b0, 1'b1, 1'b0};
        vt[13] = '{2'd1, 1'b0, 1'b0, 2'd3,  5, 5, 1'b0, 1'b1, 1'b1};
        vt[14] = '{2'd0, 1'b0, 1'b0, 2'd0,  0, 5, 1'b0, 1'b0, 1'b0};
        vt[15] = '{2'd1, 1'b0, 1'b0, 2'd1,  5, 5, 1'b0, 1'b0, 1'b0};
        vt[16] = '{2'd2, 1'b1, 1'b0, 2'd3,  5, 5, 1'b0, 1'b1, 1'b1};
        vt[17] = '{2'd0, 1'b0, 1'b0, 2'd0,  0, 5, 1'b0, 1'b0, 1'b0};
        vt[18] = '{2'd0, 1'b1, 1'b0, 2'd0,  0, 5, 1'b0, 1'b0, 1'b0};
        vt[19] = '{2'd1, 1'b0, 1'b0, 2'd1,  5, 5, 1'b0, 1'b0, 1'b0};
        vt[20] = '{2'd0, 1'b0, 1'b1, 2'd1,  5, 5, 1'b0, 1'b0, 1'b0};
        vt[21] = '{2'd2, 1'b0, 1'b0, 2'd2,  0, 5, 1'b1, 1'b0, 1'b0};
        vt[22] = '{2'd0, 1'b0, 1'b1, 2'd0,  0, 4, 1'b0, 1'b0, 1'b0};
        vt[23] = '{2'd0, 1'b0, 1'b1, 2'd0,  0, 8, 1'b0, 1'b0, 1'b0};

        // Reset held across two edges.
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", pack(2'd0, 0, STOCK_INIT, 1'b0, 1'b0, 1'b0));
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            tick(vt[i].coin, vt[i].cancel, vt[i].restock);
            check($sformatf("vec%0d", i),
                  pack(vt[i].st, vt[i].cr, vt[i].sk, vt[i].d, vt[i].c, vt[i].r));
        end

        // Eight full-price sales empty the machine; a coin then bounces until restock.
        pulse_reset("reset_before_sellout");
        for (int s = 0; s < 8; s++) begin
            tick(2'd3, 1'b0, 1'b0);
            repeat (3) tick(2'd0, 1'b0, 1'b0);
        end
        check("sold_out_stock0", pack(2'd0, 0, 0, 1'b0, 1'b0, 1'b0));
        tick(2'd1, 1'b0, 1'b0);
        check("sold_out_reject", pack(2'd0, 0, 0, 1'b0, 1'b0, 1'b1));
        tick(2'd0, 1'b0, 1'b1);
        check("restock_reload", pack(2'd0, 0, STOCK_INIT, 1'b0, 1'b0, 1'b0));

        // Reset during the first change cycle drops the remaining refund.
        tick(2'd3, 1'b0, 1'b0);
        tick(2'd0, 1'b0, 1'b0);
        check("first_change_cycle", pack(2'd3, 10, STOCK_INIT - 1, 1'b0, 1'b1, 1'b0));
        pulse_reset("reset_mid_change");
        for (int k = 0; k < 3; k++) begin
            tick(2'd0, 1'b0, 1'b0);
            check($sformatf("after_reset_quiet%0d", k), pack(2'd0, 0, STOCK_INIT, 1'b0, 1'b0, 1'b0));
        end
        tick(2'd1, 1'b0, 1'b0);
        check("after_reset_first_coin", pack(2'd1, 5, STOCK_INIT, 1'b0, 1'b0, 1'b0));

        // Random traffic against the model.
        pulse_reset("reset_before_random");
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            logic [1:0] rc;
            logic       rcn, rr;
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset("random_reset");
                model_reset();
            end else begin
                rc  = ($urandom_range(0, 9) < 4) ? 2'd0 : 2'($urandom_range(1, 3));
                rcn = ($urandom_range(0, 5) == 0);
                rr  = ($urandom_range(0, 39) == 0);
                model_step(rc, rcn, rr);
                tick(rc, rcn, rr);
                check("random", model_obs());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vending_machine_change.md
VENDING_MACHINE_CHANGE -- requirements
Module: vending_machine_change

Interface
REQ-001 The block SHALL expose parameter PRICE, default 15, meaning item price in currency units; PRICE must be a nonzero multiple of 5.
REQ-002 The block SHALL expose parameter STOCK_INIT, default 8, meaning the item count loaded at reset and on restock.
REQ-003 The block SHALL expose parameter CREDIT_W, default 6, meaning credit register width; it must hold PRICE+20.
REQ-004 The block SHALL expose parameter STOCK_W, default 4, meaning stock counter width; it must hold STOCK_INIT.
REQ-005 Port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-006 Port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 Port coin, input, 2 bits: 00 none, 01 = 5 units, 10 = 10 units, 11 = 25 units; sampled every rising edge.
REQ-008 Port cancel, input, 1 bit: refund request, level-sampled.
REQ-009 Port restock, input, 1 bit: reload stock to STOCK_INIT.
REQ-010 Port dispense, output, 1 bit: registered one-cycle vend pulse.
REQ-011 Port change_pulse, output, 1 bit: registered; each high cycle returns one 5-unit coin.
REQ-012 Port coin_reject, output, 1 bit: registered one-cycle pulse; the coin sampled on the previous edge was returned.
REQ-013 Port sold_out, output, 1 bit: combinational, high when stock == 0.
REQ-014 Port credit, output, CREDIT_W bits: current accumulated credit.
REQ-015 Port stock, output, STOCK_W bits: current item count.
REQ-016 Port state_dbg, output, 2 bits: current FSM state encoding.

Function
REQ-017 The FSM SHALL have four states: IDLE=00, CREDIT=01, VEND=10, CHANGE=11.
REQ-018 In IDLE or CREDIT with stock>0, a nonzero coin SHALL add its value to credit on the same edge.
REQ-019 If credit+coin >= PRICE, the FSM SHALL enter VEND, load credit with credit+coin-PRICE, and assert dispense for exactly the VEND cycle.
REQ-020 If credit+coin < PRICE, the FSM SHALL enter or stay in CREDIT.
REQ-021 In VEND, stock SHALL decrement by 1; the next state SHALL be CHANGE if credit>0, else IDLE.
REQ-022 In CHANGE, change_pulse SHALL be high each cycle and credit SHALL decrement by 5 per cycle; the FSM SHALL return to IDLE on the cycle credit reaches 0.
REQ-023 In CREDIT, cancel SHALL move the FSM to CHANGE without dispensing; in IDLE, cancel SHALL be ignored.
REQ-024 When cancel and a coin arrive on the same edge, cancel SHALL win, the coin SHALL NOT be credited, and coin_reject SHALL pulse.
REQ-025 Any nonzero coin SHALL be rejected (coin_reject pulse, credit unchanged) in VEND or CHANGE, or when stock == 0.
REQ-026 restock SHALL load stock to STOCK_INIT only in IDLE and SHALL be ignored in all other states.
REQ-027 Credit SHALL never exceed PRICE+20, and no arithmetic wrap SHALL occur within the declared widths.
REQ-028 A vend SHALL occur only when stock>0, so stock never underflows.
REQ-029 Total change_pulse count times 5 SHALL equal the refunded credit exactly.

Reset
REQ-030 While reset is high, the block SHALL hold: state=IDLE, credit=0, stock=STOCK_INIT, and dispense, change_pulse, coin_reject all 0.
REQ-031 Reset asserted mid-CREDIT or mid-CHANGE SHALL discard credit immediately, with no further change pulses.
REQ-032 After reset deasserts, the first active rising edge SHALL behave as IDLE.

Verification (defaults PRICE=15, STOCK_INIT=8)
REQ-033 coin 01 then 10 on consecutive edges -> credit 5, then VEND with dispense=1 for 1 cycle, credit=0, stock=7, back to IDLE; change_pulse never high.
REQ-034 single coin 11 -> VEND (credit=10, dispense 1 cycle), then 2 cycles of change_pulse, credit 10->5->0, IDLE; stock=7.
REQ-035 coin 10 then cancel -> CHANGE, 2 change_pulse cycles, dispense stays 0, stock=8.
REQ-036 8 sales of coin 11 -> stock=0 and sold_out=1; next coin 01 -> coin_reject pulse, credit 0; restock in IDLE -> stock=8, sold_out=0.
REQ-037 coin 01 during CHANGE, plus cancel with coin 10 on the same edge -> both coins rejected, credit unaffected.
REQ-038 reset pulsed during the first CHANGE cycle after coin 11 -> credit=0, IDLE, no further change_pulse, stock=STOCK_INIT.
